basilisc_mem_responder: RTL and testbench

//  Host-side end of the CPU serial bus: decodes CPU requests on tx_pins/tx_fetch/tx_jump and serves them from a

---
 rtl/basilisc_mem_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_basilisc_mem_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/basilisc_mem_responder.sv
// Host-side end of the CPU serial bus: decodes serial requests, serves them from a
// parallel memory port and serialises read data / write acks back on rx_pins.
module basilisc_mem_responder #(
    parameter int IO_BITS    = 2,
    parameter int ADDR_BITS  = 16,
    parameter int DATA_BITS  = 16,
    parameter int RESP_DELAY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_fetch,
    input  logic                 tx_jump,
    input  logic [IO_BITS-1:0]   tx_pins,
    output logic [IO_BITS-1:0]   rx_pins,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic [DATA_BITS-1:0] mem_rdata,
    input  logic                 mem_ready,
    output logic                 busy,
    output logic                 proto_err,
    output logic [ADDR_BITS-1:0] fetch_addr
);
    localparam int ADDR_CHUNKS = ADDR_BITS / IO_BITS;
    localparam int DATA_CHUNKS = DATA_BITS / IO_BITS;
    localparam int MAX_AD      = (ADDR_CHUNKS > DATA_CHUNKS) ? ADDR_CHUNKS : DATA_CHUNKS;
    localparam int MAX_CNT     = (MAX_AD > RESP_DELAY) ? MAX_AD : RESP_DELAY;
    localparam int CNT_W       = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_CHUNKS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_CHUNKS - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'((RESP_DELAY > 0) ? RESP_DELAY - 1 : 0);
    localparam logic [IO_BITS-1:0] HDR_READ  = IO_BITS'(1);
    localparam logic [IO_BITS-1:0] HDR_WRITE = IO_BITS'(2);

    typedef enum logic [2:0] {
        IDLE, RX_ADDR, RX_DATA, MEM, TX_WAIT, TX_HDR, TX_DATA
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 is_write_q, is_write_d;
    logic                 is_fetch_q, is_fetch_d;
    logic [IO_BITS-1:0]   rx_q, rx_d;
    logic                 req_q, req_d;
    logic                 we_q, we_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic [ADDR_BITS-1:0] faddr_q, faddr_d;
    logic [IO_BITS-1:0]   resp_hdr;

    assign resp_hdr = is_write_q ? HDR_WRITE : HDR_READ;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        is_fetch_d = is_fetch_q;
        rx_d       = rx_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        busy_d     = busy_q;
        err_d      = err_q;
        faddr_d    = faddr_q;

        // CPU must stay quiet while we own the bus; flag it but keep going.
        if (tx_pins != '0 && (state_q == MEM || state_q == TX_WAIT ||
                              state_q == TX_HDR || state_q == TX_DATA))
            err_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (tx_pins == HDR_READ) begin
                    busy_d     = 1'b1;
                    is_write_d = 1'b0;
                    is_fetch_d = tx_fetch;
                    cnt_d      = '0;
                    if (tx_fetch && !tx_jump) begin
                        addr_d  = faddr_q;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        state_d = MEM;
                    end else begin
                        state_d = RX_ADDR;
                    end
                end else if (tx_pins == HDR_WRITE) begin
                    busy_d     = 1'b1;
                    is_write_d = 1'b1;
                    is_fetch_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = RX_ADDR;
                    if (tx_fetch) err_d = 1'b1;
                end else if (tx_pins != '0) begin
                    err_d = 1'b1;
                end
            end
            RX_ADDR: begin
                // LSB chunk first: shift in at the top so the first chunk ends at bit 0
                addr_d = {tx_pins, addr_q[ADDR_BITS-1:IO_BITS]};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == ADDR_LAST) begin
                    cnt_d = '0;
                    if (is_write_q) begin
                        state_d = RX_DATA;
                    end else begin
                        state_d = MEM;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                    end
                end
            end
            RX_DATA: begin
                wdata_d = {tx_pins, wdata_q[DATA_BITS-1:IO_BITS]};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == DATA_LAST) begin
                    cnt_d   = '0;
                    state_d = MEM;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                end
            end
            MEM: begin
                if (mem_ready) begin
                    req_d = 1'b0;
                    we_d  = 1'b0;
                    if (!is_write_q) rdata_d = mem_rdata;
                    if (is_fetch_q)  faddr_d = addr_q + ADDR_BITS'(1);
                    cnt_d = '0;
                    if (RESP_DELAY == 0) begin
                        state_d = TX_HDR;
                        rx_d    = resp_hdr;
                    end else begin
                        state_d = TX_WAIT;
                    end
                end
            end
            TX_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DELAY_LAST) begin
                    cnt_d   = '0;
                    state_d = TX_HDR;
                    rx_d    = resp_hdr;
                end
            end
            TX_HDR: begin
                cnt_d = '0;
                if (is_write_q) begin
                    state_d = IDLE;
                    rx_d    = '0;
                    busy_d  = 1'b0;
                end else begin
                    state_d = TX_DATA;
                    rx_d    = rdata_q[IO_BITS-1:0];
                    rdata_d = rdata_q >> IO_BITS;
                end
            end
            TX_DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DATA_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    rx_d    = '0;
                    busy_d  = 1'b0;
                end else begin
                    rx_d    = rdata_q[IO_BITS-1:0];
                    rdata_d = rdata_q >> IO_BITS;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_write_q <= 1'b0;
            is_fetch_q <= 1'b0;
            rx_q       <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            faddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            is_fetch_q <= is_fetch_d;
            rx_q       <= rx_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            faddr_q    <= faddr_d;
        end
    end

    assign rx_pins    = rx_q;
    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = busy_q;
    assign proto_err  = err_q;
    assign fetch_addr = faddr_q;

endmodule

// File: tb/tb_basilisc_mem_responder.sv
// Directed bench for basilisc_mem_responder: CPU-side serial driver, a tiny memory
// with programmable ready latency, and hand-computed expected responses.
module tb_basilisc_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_fetch = 1'b0;
    logic        tx_jump = 1'b0;
    logic [1:0]  tx_pins = 2'd0;
    logic [1:0]  rx_pins;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ready = 1'b1;
    logic        busy;
    logic        proto_err;
    logic [15:0] fetch_addr;

    int n_chk = 0;
    int n_err = 0;
    int ready_delay = 0;
    int req_total = 0;
    int unstable = 0;
    int age = 0;
    logic        preq = 1'b0;
    logic        pwe = 1'b0;
    logic [15:0] paddr = 16'h0;
    logic [15:0] pwdata = 16'h0;

    basilisc_mem_responder dut (
        .clk(clk), .rst_n(rst_n), .tx_fetch(tx_fetch), .tx_jump(tx_jump),
        .tx_pins(tx_pins), .rx_pins(rx_pins), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .busy(busy), .proto_err(proto_err), .fetch_addr(fetch_addr)
    );

    always #5 clk = ~clk;

    // Memory side: ready after ready_delay req cycles; track request stability.
    always @(negedge clk) begin
        if (mem_req) begin
            if (preq && (mem_addr != paddr || mem_wdata != pwdata || mem_we != pwe))
                unstable++;
            mem_ready = (age >= ready_delay);
            age++;
            req_total++;
        end else begin
            age = 0;
            mem_ready = (ready_delay == 0);
        end
        preq = mem_req; paddr = mem_addr; pwdata = mem_wdata; pwe = mem_we;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_hdr(input logic [1:0] hdr, input logic f, input logic j);
        tx_pins = hdr; tx_fetch = f; tx_jump = j;
        step();
        tx_pins = 2'd0; tx_fetch = 1'b0; tx_jump = 1'b0;
    endtask

    task automatic send_chunks(input logic [15:0] v);
        for (int i = 0; i < 8; i++) begin
            tx_pins = v[2*i +: 2];
            step();
        end
        tx_pins = 2'd0;
    endtask

    // Waits (bounded) for the response header, then checks every chunk and the return to idle.
    task automatic collect(input string tag, input logic [1:0] hdr, input logic [15:0] data,
                           input bit has_data, input bit collide, output int lat);
        lat = 0;
        while (rx_pins == 2'd0 && lat < 40) begin
            step();
            lat++;
        end
        chk({tag, "_hdr"}, 32'(rx_pins), 32'(hdr));
        if (has_data) begin
            for (int i = 0; i < 8; i++) begin
                step();
                tx_pins = (collide && i == 0) ? 2'd1 : 2'd0;
                chk({tag, "_chunk"}, 32'(rx_pins), 32'(data[2*i +: 2]));
            end
            tx_pins = 2'd0;
        end
        step();
        chk({tag, "_rx_idle"}, 32'(rx_pins), 32'd0);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        int r0;
        int u0;
        #3;
        chk("rst_rx", 32'(rx_pins), 0);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(proto_err), 0);
        chk("rst_faddr", 32'(fetch_addr), 0);
        step(); step();
        rst_n = 1'b1;
        step();

        // No-jump fetch from address 0
        mem_rdata = 16'hBEEF;
        r0 = req_total;
        send_hdr(2'd1, 1'b1, 1'b0);
        chk("f0_busy", 32'(busy), 1);
        chk("f0_req", 32'(mem_req), 1);
        chk("f0_addr", 32'(mem_addr), 32'h0);
        chk("f0_rx", 32'(rx_pins), 0);
        collect("f0", 2'd1, 16'hBEEF, 1'b1, 1'b0, lat);
        chk("f0_lat", 32'(lat), 2);
        chk("f0_reqcyc", 32'(req_total - r0), 1);
        chk("f0_faddr", 32'(fetch_addr), 32'h1);

        // Jump fetch to 0x1234, header on the first idle cycle
        mem_rdata = 16'h00A5;
        send_hdr(2'd1, 1'b1, 1'b1);
        chk("fj_noreq", 32'(mem_req), 0);
        send_chunks(16'h1234);
        chk("fj_req", 32'(mem_req), 1);
        chk("fj_addr", 32'(mem_addr), 32'h1234);
        chk("fj_we", 32'(mem_we), 0);
        collect("fj", 2'd1, 16'h00A5, 1'b1, 1'b0, lat);
        chk("fj_lat", 32'(lat), 2);
        chk("fj_faddr", 32'(fetch_addr), 32'h1235);

        // Write with a slow memory
        ready_delay = 3;
        r0 = req_total;
        u0 = unstable;
        send_hdr(2'd2, 1'b0, 1'b0);
        send_chunks(16'h0010);
        chk("wr_noreq", 32'(mem_req), 0);
        send_chunks(16'hCAFE);
        chk("wr_req", 32'(mem_req), 1);
        chk("wr_we", 32'(mem_we), 1);
        chk("wr_addr", 32'(mem_addr), 32'h0010);
        chk("wr_wdata", 32'(mem_wdata), 32'hCAFE);
        collect("wr", 2'd2, 16'h0, 1'b0, 1'b0, lat);
        chk("wr_lat", 32'(lat), 5);
        chk("wr_reqcyc", 32'(req_total - r0), 4);
        chk("wr_stable", 32'(unstable - u0), 0);
        chk("wr_faddr", 32'(fetch_addr), 32'h1235);
        chk("wr_err", 32'(proto_err), 0);
        ready_delay = 0;
        step();

        // Wrap of the sequential fetch address
        mem_rdata = 16'h1111;
        send_hdr(2'd1, 1'b1, 1'b1);
        send_chunks(16'hFFFE);
        collect("wj", 2'd1, 16'h1111, 1'b1, 1'b0, lat);
        chk("wj_faddr", 32'(fetch_addr), 32'hFFFF);
        mem_rdata = 16'h5A0F;
        send_hdr(2'd1, 1'b1, 1'b0);
        chk("wrap_addr", 32'(mem_addr), 32'hFFFF);
        collect("wrap", 2'd1, 16'h5A0F, 1'b1, 1'b0, lat);
        chk("wrap_faddr", 32'(fetch_addr), 32'h0);

        // Illegal header
        send_hdr(2'd3, 1'b0, 1'b0);
        chk("bad_err", 32'(proto_err), 1);
        chk("bad_busy", 32'(busy), 0);
        chk("bad_req", 32'(mem_req), 0);
        step();
        chk("bad_req2", 32'(mem_req), 0);
        chk("bad_rx", 32'(rx_pins), 0);

        // Asynchronous reset while the memory request is outstanding
        ready_delay = 20;
        send_hdr(2'd1, 1'b1, 1'b1);
        send_chunks(16'h0055);
        chk("ar_req", 32'(mem_req), 1);
        step();
        rst_n = 1'b0;
        #1;
        chk("ar_req_low", 32'(mem_req), 0);
        chk("ar_addr", 32'(mem_addr), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_err", 32'(proto_err), 0);
        chk("ar_rx", 32'(rx_pins), 0);
        chk("ar_faddr", 32'(fetch_addr), 0);
        step();
        rst_n = 1'b1;
        ready_delay = 0;
        step();
        mem_rdata = 16'h7E81;
        send_hdr(2'd1, 1'b1, 1'b0);
        chk("ar_fetch_addr", 32'(mem_addr), 32'h0);
        collect("ar", 2'd1, 16'h7E81, 1'b1, 1'b0, lat);
        chk("ar_faddr_after", 32'(fetch_addr), 32'h1);

        // Collision during TX_DATA: flagged, response still intact
        mem_rdata = 16'h3C96;
        send_hdr(2'd1, 1'b1, 1'b0);
        chk("col_err_before", 32'(proto_err), 0);
        collect("col", 2'd1, 16'h3C96, 1'b1, 1'b1, lat);
        chk("col_err", 32'(proto_err), 1);
        chk("col_faddr", 32'(fetch_addr), 32'h2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "watchdog");
    end
endmodule
